fetch_unit: RTL

Instruction fetch stage feeding the IF/ID pipeline register. Owns the program counter and issues one word-aligned request per cycle to the registered instruction memory. Buffers returned instructions with their PC in a small queue and presents them to decode over a valid/ready handshake. A redirect (branch or branch-register resolution) squashes every buffered and in-flight fetch and restarts at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instr, pc} entries; flush empties it and wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset too, so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue credit check upstream must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && count == CNT_W'(DEPTH)));
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one request per cycle to registered imem,
// and queues returned instructions for decode; redirect squashes everything.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              kill;
  logic [CNT_W-1:0]  count;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  // Credit check counts the in-flight slot but ignores a same-cycle pop.
  assign issue = !rst && !redirect && ((int'(count) + int'(inflight)) < DEPTH);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  assign push      = inflight && !kill && !redirect;
  assign push_data = '{instr: imem_rdata, pc: inflight_pc};
  assign pop       = id_valid && id_ready && !redirect;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      fetch_pc    <= word_align(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= word_align(redirect_pc);
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(4);
        inflight_pc <= fetch_pc;
      end
      if (inflight && kill) kill <= 1'b0;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign id_valid    = (count != '0);
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_pc_plus4 = head.pc + ADDR_W'(4);

endmodule
